// File: rtl/cond_hazard_controller.sv
// Execute-stage hazard sequencer: turns taken branches, flag dependencies and
// load-use conflicts into stall/flush controls for the F/D and D/E registers.
// Optional statistics counters are enabled with the COND_HAZARD_STATS_EN macro.
module cond_hazard_controller #(
    parameter int FLUSH_DEPTH = 2,
    parameter int FLAG_LAT    = 1,
    parameter int CNT_W       = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ValidD,
    input  logic       ValidE,
    input  logic       PCSrcE,
    input  logic       FlagWriteE,
    input  logic       CondD,
    input  logic       LoadE,
    input  logic [3:0] RdE,
    input  logic [3:0] Rs1D,
    input  logic [3:0] Rs2D,
    output logic       StallF,
    output logic       StallD,
    output logic       FlushD,
    output logic       FlushE,
    output logic       busy,
    output logic [1:0] state
`ifdef COND_HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        REDIRECT  = 2'b01,
        FLAG_WAIT = 2'b10,
        ILLEGAL   = 2'b11
    } state_t;

    // Remaining-cycle preloads; the first hazard cycle is spent in RUN.
    localparam logic [2:0] FLUSH_REM = 3'(FLUSH_DEPTH - 1);
    localparam logic [2:0] FLAG_REM  = 3'(FLAG_LAT - 1);

    state_t     state_q, state_n;
    logic [2:0] rem_q, rem_n;
    logic       br, fh, lu;

    assign br = PCSrcE & ValidE;
    assign fh = CondD & ValidD & FlagWriteE & ValidE;
    assign lu = LoadE & ValidE & ValidD & (RdE != 4'd0) &
                ((RdE == Rs1D) | (RdE == Rs2D));

    // State and remaining-cycle counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            rem_q   <= 3'd0;
        end else begin
            state_q <= state_n;
            rem_q   <= rem_n;
        end
    end

    // Next-state and control outputs: Mealy in RUN, Moore elsewhere
    always_comb begin
        state_n = RUN;
        rem_n   = rem_q;
        StallF  = 1'b0;
        StallD  = 1'b0;
        FlushD  = 1'b0;
        FlushE  = 1'b0;
        case (state_q)
            RUN: begin
                if (br) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (FLUSH_DEPTH > 1) begin
                        state_n = REDIRECT;
                        rem_n   = FLUSH_REM;
                    end
                end else if (fh) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    if (FLAG_LAT > 1) begin
                        state_n = FLAG_WAIT;
                        rem_n   = FLAG_REM;
                    end
                end else if (lu) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end
            end
            REDIRECT: begin
                // E now holds the target instruction, so br is not re-serviced here
                FlushD = 1'b1;
                if (rem_q > 3'd1) begin
                    state_n = REDIRECT;
                    rem_n   = rem_q - 3'd1;
                end
            end
            FLAG_WAIT: begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
                if (rem_q > 3'd1) begin
                    state_n = FLAG_WAIT;
                    rem_n   = rem_q - 3'd1;
                end
            end
            default: begin
                state_n = RUN;
            end
        endcase
        if (!rst) begin
            StallF = 1'b0;
            StallD = 1'b0;
            FlushD = 1'b0;
            FlushE = 1'b0;
        end
    end

    // Status view of the FSM, forced to RUN while reset is asserted
    always_comb begin
        state = rst ? state_q : RUN;
        busy  = (state != RUN);
    end

`ifdef COND_HAZARD_STATS_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                  input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + 1'b1;
        return v;
    endfunction

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            branch_cnt <= '0;
            stall_cnt  <= '0;
            flush_cnt  <= '0;
        end else begin
            branch_cnt <= sat_inc(branch_cnt, (state_q == RUN) && br);
            stall_cnt  <= sat_inc(stall_cnt, StallF);
            flush_cnt  <= sat_inc(flush_cnt, FlushD);
        end
    end
`endif

endmodule

// File: tb/tb_cond_hazard_controller.sv
// Bench for cond_hazard_controller: directed steps followed by random traffic,
// every cycle compared against a cycle-count model of the hazard rules.
module tb_cond_hazard_controller;

    localparam int FD   = 2;
    localparam int FL   = 3;
    localparam int CW   = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ValidD, ValidE, PCSrcE, FlagWriteE, CondD, LoadE;
    logic [3:0] RdE, Rs1D, Rs2D;
    logic       StallF, StallD, FlushD, FlushE, busy;
    logic [1:0] state;
`ifdef COND_HAZARD_STATS_EN
    logic [CW-1:0] branch_cnt, stall_cnt, flush_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Model: cycles still owed to a redirect or a flag wait, plus event counts
    int red_left  = 0;
    int flag_left = 0;
    int m_bcnt = 0, m_scnt = 0, m_fcnt = 0;

    cond_hazard_controller #(
        .FLUSH_DEPTH(FD),
        .FLAG_LAT(FL),
        .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .ValidD(ValidD), .ValidE(ValidE), .PCSrcE(PCSrcE),
        .FlagWriteE(FlagWriteE), .CondD(CondD), .LoadE(LoadE),
        .RdE(RdE), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .busy(busy), .state(state)
`ifdef COND_HAZARD_STATS_EN
        , .branch_cnt(branch_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic vd, input logic ve, input logic pc,
                          input logic fw, input logic cd, input logic ld,
                          input logic [3:0] rd, input logic [3:0] r1,
                          input logic [3:0] r2);
        ValidD = vd; ValidE = ve; PCSrcE = pc; FlagWriteE = fw;
        CondD = cd; LoadE = ld; RdE = rd; Rs1D = r1; Rs2D = r2;
    endtask

    task automatic idle_in();
        set_in(0, 0, 0, 0, 0, 0, 4'd0, 4'd0, 4'd0);
    endtask

    function automatic int sat(input int v);
        return (v >= (1 << CW) - 1) ? (1 << CW) - 1 : v + 1;
    endfunction

    // One clock: check outputs at the falling edge, advance the model at the rising edge
    task automatic step(input string tag);
        logic br, fh, lu;
        logic esf, esd, efd, efe;
        logic [1:0] est;
        logic [6:0] obs, expv;
        logic took_br;
        @(negedge clk);
        br = PCSrcE & ValidE;
        fh = CondD & ValidD & FlagWriteE & ValidE;
        lu = LoadE & ValidE & ValidD & (RdE != 0) & ((RdE == Rs1D) || (RdE == Rs2D));
        esf = 0; esd = 0; efd = 0; efe = 0; est = 2'd0; took_br = 0;
        if (rst) begin
            if (red_left > 0) begin
                est = 2'd1; efd = 1;
            end else if (flag_left > 0) begin
                est = 2'd2; esf = 1; esd = 1; efe = 1;
            end else if (br) begin
                efd = 1; efe = 1; took_br = 1;
            end else if (fh || lu) begin
                esf = 1; esd = 1; efe = 1;
            end
        end
        obs  = {busy, state, StallF, StallD, FlushD, FlushE};
        expv = {est != 2'd0, est, esf, esd, efd, efe};
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: {busy,state,SF,SD,FD,FE} observed=%b expected=%b", tag, obs, expv);
        end
`ifdef COND_HAZARD_STATS_EN
        n_checks++;
        assert ({branch_cnt, stall_cnt, flush_cnt} ===
                {CW'(m_bcnt), CW'(m_scnt), CW'(m_fcnt)}) else begin
            n_fail++;
            $error("FAIL %s_cnt: observed b=%0d s=%0d f=%0d expected b=%0d s=%0d f=%0d",
                   tag, branch_cnt, stall_cnt, flush_cnt, m_bcnt, m_scnt, m_fcnt);
        end
`endif
        @(posedge clk);
        if (!rst) begin
            red_left = 0; flag_left = 0;
            m_bcnt = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            if (took_br) m_bcnt = sat(m_bcnt);
            if (esf) m_scnt = sat(m_scnt);
            if (efd) m_fcnt = sat(m_fcnt);
            if (red_left > 0) red_left--;
            else if (flag_left > 0) flag_left--;
            else if (br) red_left = FD - 1;
            else if (fh) flag_left = FL - 1;
        end
        #1;
    endtask

    initial begin
        // Reset held for two cycles with a branch present
        rst = 1'b0;
        idle_in();
        PCSrcE = 1; ValidE = 1;
        step("reset0");
        step("reset1");
        rst = 1'b1;
        step("post_reset_br");
        idle_in();
        step("redirect_after_reset");
        step("idle0");

        // Single branch pulse
        set_in(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        step("br_c0");
        idle_in();
        step("br_c1");
        step("br_c2");

        // Flag hazard held through the wait
        set_in(1, 1, 0, 1, 1, 0, 4'd0, 4'd0, 4'd0);
        step("fh_c0");
        step("fh_c1");
        step("fh_c2");
        idle_in();
        step("fh_done");

        // Load-use on Rs2, then with destination r0
        set_in(1, 1, 0, 0, 0, 1, 4'd5, 4'd1, 4'd5);
        step("lu_hit");
        idle_in();
        step("lu_after");
        set_in(1, 1, 0, 0, 0, 1, 4'd0, 4'd0, 4'd0);
        step("lu_r0");

        // Branch beats flag hazard
        set_in(1, 1, 1, 1, 1, 0, 4'd0, 4'd0, 4'd0);
        step("br_over_fh");
        idle_in();
        step("br_over_fh_c1");
        step("idle1");

        // Three branches back to back in time
        for (int i = 0; i < 3; i++) begin
            set_in(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
            step("br3_a");
            idle_in();
            step("br3_b");
        end
        step("br3_end");

        // Reset pulse in the middle of a redirect
        set_in(0, 1, 1, 0, 0, 0, 4'd0, 4'd0, 4'd0);
        step("mid_br");
        idle_in();
        rst = 1'b0;
        step("mid_rst");
        rst = 1'b1;
        step("mid_rst_after");

        // Random traffic with occasional reset pulses
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 49) != 0);
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 3) == 0),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                   4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                   4'($urandom_range(0, 7)));
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cond_hazard_controller.md
Name: cond_hazard_controller

Overview:
- Execute-stage sequencer around conditional_unit in the pipelined processor.
- Turns the resolved branch (PCSrcE), the flag-update intent (FlagWriteE) and load-use conditions into stall and flush controls for the Fetch, Decode and Execute pipeline registers.
- Holds a small FSM so multi-cycle flushes and flag waits are sequenced deterministically.
- Sits beside the hazard path; drives the enable and clear inputs of the F/D and D/E registers.

Parameters:
- FLUSH_DEPTH, 2, total cycles FlushD is asserted after a taken branch (range 1..7)
- FLAG_LAT, 1, cycles between flag-writing instr in E and flags visible to a conditional instr (range 1..7)
- CNT_W, 16, width of statistics counters (optional feature only)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-low (0 = reset)
- ValidD  in  1  Decode holds a real instruction
- ValidE  in  1  Execute holds a real instruction
- PCSrcE  in  1  taken branch / PC write from conditional_unit
- FlagWriteE  in  1  instr in E updates flags
- CondD  in  1  instr in D is conditional (reads flags)
- LoadE  in  1  instr in E is a memory load
- RdE  in  4  destination register of E
- Rs1D  in  4  source register 1 of D
- Rs2D  in  4  source register 2 of D
- StallF  out  1  hold PC
- StallD  out  1  hold F/D register
- FlushD  out  1  clear F/D register
- FlushE  out  1  clear D/E register (insert bubble)
- busy  out  1  FSM not in RUN
- state  out  2  FSM state encoding: RUN=00, REDIRECT=01, FLAG_WAIT=10

Behaviour:
- While rst==0: all outputs 0. State goes to RUN and counters clear at the next rising edge. This applies mid-operation as well: an in-progress REDIRECT or FLAG_WAIT is abandoned immediately.
- Outputs are Mealy in RUN (same-cycle response) and Moore in the other states.
- Hazard terms:
  - br = PCSrcE & ValidE
  - fh = CondD & ValidD & FlagWriteE & ValidE
  - lu = LoadE & ValidE & ValidD & (RdE != 0) & ((RdE == Rs1D) | (RdE == Rs2D))
- Priority: br > fh > lu. Only one hazard is serviced per cycle.
- RUN, on br:
  - FlushD=1, FlushE=1, StallF=0, StallD=0.
  - If FLUSH_DEPTH>1: load rem = FLUSH_DEPTH-1 and go to REDIRECT. Otherwise stay in RUN.
- RUN, on fh (no br):
  - StallF=1, StallD=1, FlushE=1.
  - If FLAG_LAT>1: load rem = FLAG_LAT-1 and go to FLAG_WAIT. Otherwise stay in RUN.
- RUN, on lu (no br, no fh): StallF=1, StallD=1, FlushE=1 for exactly one cycle; stay in RUN.
- RUN, no hazard: all outputs 0.
- REDIRECT:
  - FlushD=1, FlushE=0, stalls 0.
  - rem decrements each cycle; return to RUN when rem==1 at the clock edge.
  - br is ignored here (E holds the instruction fetched from the target).
- FLAG_WAIT:
  - StallF=1, StallD=1, FlushE=1.
  - rem decrements; return to RUN when rem==1.
  - Inputs are ignored except rst.
- rem is a 3-bit down-counter; it never wraps below 1.
- Illegal state 11 returns to RUN on the next edge with outputs 0.
- busy = (state != RUN).

Optional Feature:
- Macro: COND_HAZARD_STATS_EN.
- Defined:
  - Adds outputs branch_cnt[CNT_W-1:0], stall_cnt[CNT_W-1:0] and flush_cnt[CNT_W-1:0].
  - Each counter increments by 1 per cycle on, respectively: br accepted in RUN; any cycle with StallF=1; any cycle with FlushD=1.
  - Counters saturate at all-ones and clear on reset.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset with rst=0 held for 2 cycles while PCSrcE=1, ValidE=1 -> all outputs 0 and state=00; after release, FlushD=FlushE=1 in the first cycle.
- FLUSH_DEPTH=2, one-cycle pulse PCSrcE=1, ValidE=1 -> cycle 0: FlushD=1, FlushE=1; cycle 1: state=01, FlushD=1, FlushE=0; cycle 2: state=00, all 0.
- FLAG_LAT=3, CondD=1, ValidD=1, FlagWriteE=1, ValidE=1 held -> StallF=StallD=FlushE=1 for 3 consecutive cycles (state 00, 10, 10), then 0 once inputs drop.
- LoadE=1, RdE=5, Rs2D=5, ValidD=ValidE=1 for one cycle -> one-cycle StallF=StallD=FlushE=1; repeat with RdE=0 -> no stall.
- Simultaneous PCSrcE=1 and fh=1 in RUN -> branch wins: FlushD=1, StallF=0.
- With COND_HAZARD_STATS_EN: 3 taken branches at FLUSH_DEPTH=2 -> branch_cnt=3, flush_cnt=6. Pulse rst=0 mid-REDIRECT -> all counters 0 and state=00.
